// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// 32 shift-add or restoring-divide steps, then a sign fix-up cycle.
`timescale 1ns/1ps
module muldiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        mt_hi,
  input  logic        mt_lo,
  input  logic [31:0] mt_value,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;

  logic [1:0]  state;
  logic        is_div;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] orig_a;
  logic [63:0] acc;
  logic [4:0]  count;

  logic        in_neg_a;
  logic        in_neg_b;
  logic [31:0] in_mag_a;
  logic [31:0] in_mag_b;
  logic [32:0] mul_sum;
  logic [63:0] acc_mul;
  logic [32:0] rem_shift;
  logic [31:0] rem_diff;
  logic [63:0] acc_div;
  logic [63:0] product;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign fsm_state = state;

  // Signed ops (op[0]==0) work on magnitudes; the signs are re-applied in FIXUP.
  always_comb begin
    in_neg_a = ~op[0] & operand_a[31];
    in_neg_b = ~op[0] & operand_b[31];
    in_mag_a = in_neg_a ? (~operand_a + 32'd1) : operand_a;
    in_mag_b = in_neg_b ? (~operand_b + 32'd1) : operand_b;
  end

  // Multiply: multiplier sits in acc[31:0], partial product grows in acc[63:32].
  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
    acc_mul = {mul_sum, acc[31:1]};
  end

  // Divide: remainder in acc[63:32], dividend/quotient bits shift through acc[31:0].
  always_comb begin
    rem_shift = acc[63:31];
    rem_diff  = rem_shift[31:0] - mag_b;
    if (rem_shift >= {1'b0, mag_b}) acc_div = {rem_diff, acc[30:0], 1'b1};
    else                            acc_div = {acc[62:0], 1'b0};
  end

  always_comb begin
    product  = (neg_a ^ neg_b) ? (~acc + 64'd1) : acc;
    quot_fix = (neg_a ^ neg_b) ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_fix  = neg_a ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      mag_a  <= 32'd0;
      mag_b  <= 32'd0;
      orig_a <= 32'd0;
      acc    <= 64'd0;
      count  <= 5'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mt_hi) hi <= mt_value;
          if (mt_lo) lo <= mt_value;
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            is_div <= op[1];
            neg_a  <= in_neg_a;
            neg_b  <= in_neg_b;
            mag_a  <= in_mag_a;
            mag_b  <= in_mag_b;
            orig_a <= operand_a;
            acc    <= {32'd0, op[1] ? in_mag_a : in_mag_b};
            count  <= 5'd0;
          end
        end
        RUN: begin
          acc   <= is_div ? acc_div : acc_mul;
          count <= count + 5'd1;
          if (count == 5'd31) state <= FIXUP;
        end
        FIXUP: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (!is_div) begin
            hi <= product[63:32];
            lo <= product[31:0];
          end else if (mag_b == 32'd0) begin
            // Divide by zero: no trap, quotient saturates and HI keeps the dividend.
            hi <= orig_a;
            lo <= 32'hFFFF_FFFF;
          end else begin
            hi <= rem_fix;
            lo <= quot_fix;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic results, timing, MT rules,
// reset abort and back-to-back acceptance.
`timescale 1ns/1ps
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        mt_hi;
  logic        mt_lo;
  logic [31:0] mt_value;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  always #5 clock = ~clock;

  muldiv_unit dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .mt_hi     (mt_hi),
    .mt_lo     (mt_lo),
    .mt_value  (mt_value),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .fsm_state (fsm_state)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives start for one edge (E0); returns at the falling edge right after E0.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Counts falling edges until done, with a bound; also counts cycles with busy high.
  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_cyc++;
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic run_and_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    int bc;
    start_op(o, a, b);
    wait_done(cyc, bc);
    check({tag, " latency"}, 64'(cyc), 64'd33);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int cyc;
    int bc;
    int done_seen;
    int first_done;
    int second_done;
    reset = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    mt_hi = 1'b0; mt_lo = 1'b0; mt_value = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset state", 64'(fsm_state), 64'd0);

    // MULTU with full timing checks
    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, bc);
    check("multu latency", 64'(cyc), 64'd33);
    check("multu busy cycles", 64'(bc), 64'd33);
    check("multu done", 64'(done), 64'd1);
    check("multu busy at done", 64'(busy), 64'd0);
    check("multu hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu lo", 64'(lo), 64'h0000_0001);
    @(negedge clock);
    check("multu done one cycle", 64'(done), 64'd0);

    run_and_check("mult neg", OP_MULT, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
    run_and_check("mult min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_and_check("div neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_and_check("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_and_check("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_and_check("divu zero", OP_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    run_and_check("div zero", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // start and mt_hi while busy are ignored; operand changes have no effect
    start_op(OP_MULTU, 32'd3, 32'd5);
    repeat (4) @(negedge clock);
    start = 1'b1; op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd7;
    mt_hi = 1'b1; mt_value = 32'hAAAA_5555;
    @(negedge clock);
    start = 1'b0; mt_hi = 1'b0;
    check("busy mt_hi ignored", 64'(hi), 64'hFFFF_FFFB);
    check("busy still busy", 64'(busy), 64'd1);
    wait_done(cyc, bc);
    check("busy ignore done", 64'(done), 64'd1);
    check("busy ignore hi", 64'(hi), 64'h0);
    check("busy ignore lo", 64'(lo), 64'd15);
    @(negedge clock);
    check("busy start not queued", 64'(busy), 64'd0);

    // MTLO in IDLE
    mt_lo = 1'b1; mt_value = 32'h0000_1234;
    @(negedge clock);
    mt_lo = 1'b0;
    check("mtlo lo", 64'(lo), 64'h1234);
    check("mtlo hi kept", 64'(hi), 64'h0);

    // MTHI together with start: MT visible until FIXUP
    @(negedge clock);
    mt_hi = 1'b1; mt_value = 32'h0000_0055;
    op = OP_MULTU; operand_a = 32'd2; operand_b = 32'd3; start = 1'b1;
    @(negedge clock);
    mt_hi = 1'b0; start = 1'b0;
    check("mt+start hi", 64'(hi), 64'h55);
    check("mt+start busy", 64'(busy), 64'd1);
    wait_done(cyc, bc);
    check("mt+start latency", 64'(cyc), 64'd33);
    check("mt+start hi final", 64'(hi), 64'h0);
    check("mt+start lo final", 64'(lo), 64'd6);

    // Reset at E10 aborts the operation
    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort hi", 64'(hi), 64'h0);
    check("abort lo", 64'(lo), 64'h0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) done_seen++;
    end
    check("abort no done", 64'(done_seen), 64'd0);

    // start held high: accepts every 34 edges, done coincides with next accept
    @(negedge clock);
    op = OP_MULTU; operand_a = 32'd2; operand_b = 32'd3; start = 1'b1;
    @(negedge clock);
    first_done = -1;
    second_done = -1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clock);
      if (done && first_done < 0) first_done = i;
      else if (done && second_done < 0) second_done = i;
      if (i == 34) check("b2b busy after done", 64'(busy), 64'd1);
    end
    start = 1'b0;
    check("b2b first done", 64'(first_done), 64'd33);
    check("b2b second done", 64'(second_done), 64'd67);
    check("b2b lo", 64'(lo), 64'd6);
    wait_done(cyc, bc);
    check("b2b drain done", 64'(done), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit in the execute stage, directly downstream of the register file. It consumes the two register read values (rs, rt), computes MULT/MULTU/DIV/DIVU over multiple cycles, and holds the 64-bit result in architectural HI/LO registers. While an operation runs it raises `busy` so the pipeline control can stall dependent MFHI/MFLO instructions.

## Interface
- none: 32-bit datapath, fixed

- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request a new operation; sampled only while idle
- `op`  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- `operand_a`  in  32  rs value: multiplicand or dividend
- `operand_b`  in  32  rt value: multiplier or divisor
- `mt_hi`  in  1  MTHI write strobe
- `mt_lo`  in  1  MTLO write strobe
- `mt_value`  in  32  data for MTHI/MTLO
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse; HI/LO hold the new result
- `hi`  out  32  HI register: product high word, or remainder
- `lo`  out  32  LO register: product low word, or quotient

## Operation
- **FSM states:** IDLE, RUN, FIXUP.
- **IDLE:**
  - On `start`=1, latch `op`, |operand_a| and |operand_b| (magnitudes for signed ops), result sign(s) and the original `operand_a`.
  - Clear the iteration counter and go to RUN.
- **RUN:** 32 iterations, one per cycle, on a 64-bit accumulator.
  - Multiply: shift-add.
  - Divide: restoring, one quotient bit per cycle.
  - After the 32nd iteration go to FIXUP.
- **FIXUP:** write HI/LO, pulse `done`, return to IDLE.
  - MULT: negate the 64-bit product if sign(a) XOR sign(b).
  - DIV: negate the quotient if sign(a) XOR sign(b); negate the remainder if sign(a).
- **Divide by zero** (`operand_b`=0, DIV or DIVU): no exception. Result is LO=0xFFFFFFFF, HI=original `operand_a`.
- **DIV 0x80000000 / 0xFFFFFFFF:** LO=0x80000000, HI=0. This is the natural magnitude-algorithm result and needs no special case.
- **Operand stability:** operands are latched at accept; changes on `operand_a`/`operand_b` during RUN have no effect.
- **`start` while busy:** ignored, not queued.
- **MTHI/MTLO:**
  - In IDLE, `mt_hi`/`mt_lo` write `hi`/`lo` on the next edge.
  - While busy they are ignored.
  - `mt_*` and `start` in the same IDLE cycle: both take effect; the MT value is visible until FIXUP overwrites it.
- **Reset:** `hi`=0, `lo`=0, `busy`=0, `done`=0, FSM=IDLE.
  - Reset asserted mid-operation aborts it: no `done`, HI/LO=0.
  - Reset has priority over `start` and `mt_*`.

## Timing
- Edge E0: `start` sampled high in IDLE.
- After E0 through after E32: `busy`=1. Iterations occur on edges E1–E32.
- Edge E33 (FIXUP):
  - `hi`/`lo` update.
  - `done`=1 for exactly the following cycle.
  - `busy`=0 from that cycle on.
- Total latency: 33 cycles from the accept edge to a valid result.
- A new `start` may be sampled in the same cycle that `done`=1; back-to-back operations are therefore 34 edges apart.
- `done` and `busy` are registered. `hi`/`lo` are register outputs with no combinational bypass.
- MTHI/MTLO take effect one edge after the strobe.

## Test plan
- **MULTU:** a=0xFFFFFFFF, b=0xFFFFFFFF, `start` at E0 -> `busy`=1 for 33 cycles; after E33 HI=0xFFFFFFFE, LO=0x00000001, `done`=1 for one cycle.
- **MULT:** a=-7 (0xFFFFFFF9), b=6 -> HI=0xFFFFFFFF, LO=0xFFFFFFD6; then a=0x80000000, b=0x80000000 -> HI=0x40000000, LO=0.
- **DIV:** a=-7, b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - DIVU: a=100, b=7 -> LO=14, HI=2.
  - DIV: a=0x80000000, b=-1 -> LO=0x80000000, HI=0.
- **Divide by zero:** DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678. DIV with a=-5, b=0 -> HI=0xFFFFFFFB.
- **Busy rules:**
  - During RUN, pulse `start` with new operands and pulse `mt_hi` with value 0xAAAA5555 -> both ignored; the original result appears after E33.
  - In IDLE, `mt_lo` with 0x1234 -> `lo`=0x1234 after one edge.
- **Reset and back-to-back:**
  - Assert `reset` at E10 of a MULTU -> next cycle `busy`=0, `hi`=`lo`=0, and no `done` ever appears.
  - Hold `start` high continuously -> operations are accepted every 34 edges, with `done` coinciding with the next accept.
